// File: rtl/vwb_pkg.sv
// ---------------------------------------------------------------------------
// vwb_pkg
//   Shared types, defaults and helpers for the victim write-back drain
//   buffer (vwb_drain_buffer) and its address comparator (vwb_addr_match).
//
//   Contents:
//     VWB_DEFAULT_DEPTH   default FIFO depth
//     VWB_DEFAULT_ADDR_W  default word-address width
//     vwb_entry_t         one queued write {addr, data, be} at default width
//     be_merge()          byte-enable merge of a new write into an old entry,
//                         returns {data[15:0], be[1:0]}
// ---------------------------------------------------------------------------
package vwb_pkg;

   localparam int VWB_DEFAULT_DEPTH  = 4;
   localparam int VWB_DEFAULT_ADDR_W = 19;

   typedef struct packed {
      logic [VWB_DEFAULT_ADDR_W-1:0] addr;
      logic [15:0]                   data;
      logic [1:0]                    be;
   } vwb_entry_t;

   // Bytes enabled in new_be overwrite the old data; the resulting entry
   // carries the union of both byte-enable sets.
   function automatic logic [17:0] be_merge(
      input logic [15:0] old_data,
      input logic [1:0]  old_be,
      input logic [15:0] new_data,
      input logic [1:0]  new_be
   );
      logic [15:0] merged;
      merged[15:8] = new_be[1] ? new_data[15:8] : old_data[15:8];
      merged[7:0]  = new_be[0] ? new_data[7:0]  : old_data[7:0];
      return {merged, old_be | new_be};
   endfunction

endpackage

// File: rtl/vwb_addr_match.sv
// ---------------------------------------------------------------------------
// vwb_addr_match
//   DEPTH-wide equality comparator array. Reports whether any entry whose
//   valid bit is set holds an address equal to i_probe. Purely combinational.
//   Used for the fill-read probe and for the youngest-entry coalesce compare.
//
//   Ports:
//     i_addrs  [DEPTH][ADDR_W]  entry addresses
//     i_valid  [DEPTH]          entry qualifying mask
//     i_probe  [ADDR_W]         address to look for
//     o_hit                     1 when a qualified entry matches
// ---------------------------------------------------------------------------
module vwb_addr_match
   import vwb_pkg::*;
#(
   parameter int DEPTH  = VWB_DEFAULT_DEPTH,
   parameter int ADDR_W = VWB_DEFAULT_ADDR_W
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] i_addrs,
   input  logic [DEPTH-1:0]             i_valid,
   input  logic [ADDR_W-1:0]            i_probe,
   output logic                         o_hit
);

   logic [DEPTH-1:0] w_match;

   always_comb begin
      w_match = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_match[i] = i_valid[i] && (i_addrs[i] == i_probe);
      end
   end

   assign o_hit = |w_match;

endmodule

// File: rtl/vwb_drain_buffer.sv
// ---------------------------------------------------------------------------
// vwb_drain_buffer
//   Memory-side responder for the cache victim write-back port. Posted word
//   writes are acknowledged, queued in a DEPTH-entry FIFO and drained in
//   order to the SDRAM arbiter write port. An address probe lets the fill
//   read path stall while a read would overtake a pending write.
//
//   Optional build macro:
//     VWB_COALESCE_EN  merge a write into the youngest queued entry when the
//                      addresses match and that entry is not the head.
//
//   Handshakes:
//     vwb_access is the request (held by the cache); vwb_ack is a one-cycle
//     acceptance pulse registered the cycle after capture. d_access is the
//     head-valid write request; d_ack is a one-cycle pulse that pops the
//     head. Head fields are stable while d_access is high and d_ack is low.
//
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     vwb_addr/data_out/bytesel  incoming write beat
//     vwb_access, vwb_wr_en      request qualifiers (wr_en must be 1)
//     vwb_ack                    acceptance pulse
//     d_addr/d_data/d_bytesel    head entry (0 while empty)
//     d_access, d_wr_en          head valid / write request
//     d_ack                      head pop pulse
//     probe_addr, probe_hit      pending-write address probe
//     empty, count               occupancy status
// ---------------------------------------------------------------------------
module vwb_drain_buffer
   import vwb_pkg::*;
#(
   parameter int DEPTH  = VWB_DEFAULT_DEPTH,
   parameter int ADDR_W = VWB_DEFAULT_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        vwb_addr,
   input  logic [15:0]              vwb_data_out,
   input  logic                     vwb_access,
   input  logic                     vwb_wr_en,
   input  logic [1:0]               vwb_bytesel,
   output logic                     vwb_ack,
   output logic [ADDR_W-1:0]        d_addr,
   output logic [15:0]              d_data,
   output logic [1:0]               d_bytesel,
   output logic                     d_access,
   output logic                     d_wr_en,
   input  logic                     d_ack,
   input  logic [ADDR_W-1:0]        probe_addr,
   output logic                     probe_hit,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Pointers carry one extra wrap bit above the index.
   logic [CW-1:0]     r_wr_ptr;
   logic [CW-1:0]     r_rd_ptr;
   logic              r_ack;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [15:0]       r_data [DEPTH];
   logic [1:0]        r_be   [DEPTH];

   logic [AW-1:0]                w_wr_idx;
   logic [AW-1:0]                w_rd_idx;
   logic [CW-1:0]                w_count;
   logic                         w_empty;
   logic                         w_full;
   logic                         w_req;
   logic                         w_be_zero;
   logic                         w_merge;
   logic                         w_capture;
   logic                         w_alloc;
   logic                         w_pop;
   logic [DEPTH-1:0]             w_valid;
   logic [DEPTH-1:0][ADDR_W-1:0] w_addr_flat;

   assign w_wr_idx  = r_wr_ptr[AW-1:0];
   assign w_rd_idx  = r_rd_ptr[AW-1:0];
   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A request is never looked at in the cycle its ack is on the wire, which
   // keeps a held request from being captured twice.
   assign w_req     = vwb_access & vwb_wr_en & ~r_ack;
   assign w_be_zero = (vwb_bytesel == 2'b00);

   // Entry i is valid when its distance from the head is below the count.
   always_comb begin
      logic [AW-1:0] off;
      w_valid     = '0;
      w_addr_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off            = AW'(i) - w_rd_idx;
         w_valid[i]     = ({1'b0, off} < w_count);
         w_addr_flat[i] = r_addr[i];
      end
   end

   vwb_addr_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_probe_match (
      .i_addrs (w_addr_flat),
      .i_valid (w_valid),
      .i_probe (probe_addr),
      .o_hit   (probe_hit)
   );

`ifdef VWB_COALESCE_EN
   logic [AW-1:0]    w_tail_idx;
   logic [DEPTH-1:0] w_tail_mask;
   logic             w_tail_hit;

   assign w_tail_idx = w_wr_idx - AW'(1);

   // Only the youngest entry is a merge candidate, and never the head: the
   // head may be on the d_* bus already and must not change under it.
   always_comb begin
      w_tail_mask = '0;
      if (w_count >= CW'(2)) begin
         w_tail_mask[w_tail_idx] = 1'b1;
      end
   end

   vwb_addr_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_tail_match (
      .i_addrs (w_addr_flat),
      .i_valid (w_tail_mask),
      .i_probe (vwb_addr),
      .o_hit   (w_tail_hit)
   );

   assign w_merge = w_req & ~w_be_zero & w_tail_hit;
`else
   assign w_merge = 1'b0;
`endif

   // Full blocks allocation only; a merge needs no new slot. Fullness is
   // taken from the registered pointers, so a same-cycle pop cannot make
   // room for this cycle's push.
   assign w_capture = w_req & (~w_full | w_merge);
   assign w_alloc   = w_capture & ~w_be_zero & ~w_merge;
   assign w_pop     = d_ack & ~w_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ack    <= 1'b0;
      end else begin
         r_ack <= w_capture;
         if (w_alloc) begin
            r_wr_ptr <= r_wr_ptr + CW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + CW'(1);
         end
      end
   end

   // Storage needs no reset: validity comes entirely from the pointers.
   always_ff @(posedge clk) begin
      if (w_alloc) begin
         r_addr[w_wr_idx] <= vwb_addr;
         r_data[w_wr_idx] <= vwb_data_out;
         r_be[w_wr_idx]   <= vwb_bytesel;
      end
`ifdef VWB_COALESCE_EN
      else if (w_merge) begin
         {r_data[w_tail_idx], r_be[w_tail_idx]} <=
            be_merge(r_data[w_tail_idx], r_be[w_tail_idx], vwb_data_out, vwb_bytesel);
      end
`endif
   end

   assign vwb_ack   = r_ack;
   assign d_access  = ~w_empty;
   assign d_wr_en   = ~w_empty;
   assign d_addr    = w_empty ? '0    : r_addr[w_rd_idx];
   assign d_data    = w_empty ? 16'h0 : r_data[w_rd_idx];
   assign d_bytesel = w_empty ? 2'b00 : r_be[w_rd_idx];
   assign empty     = w_empty;
   assign count     = w_count;

endmodule

// File: tb/tb_vwb_drain_buffer.sv
module tb_vwb_drain_buffer;
  import vwb_pkg::*;

  localparam int ADDR_W = 19;
  localparam int DEPTH  = 4;
  localparam int W      = $bits(vwb_entry_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] vwb_addr;
  logic [15:0]       vwb_data_out;
  logic              vwb_access;
  logic              vwb_wr_en;
  logic [1:0]        vwb_bytesel;
  logic              vwb_ack;
  logic [ADDR_W-1:0] d_addr;
  logic [15:0]       d_data;
  logic [1:0]        d_bytesel;
  logic              d_access;
  logic              d_wr_en;
  logic              d_ack;
  logic [ADDR_W-1:0] probe_addr;
  logic              probe_hit;
  logic              empty;
  logic [2:0]        count;

  vwb_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .vwb_addr     (vwb_addr),
    .vwb_data_out (vwb_data_out),
    .vwb_access   (vwb_access),
    .vwb_wr_en    (vwb_wr_en),
    .vwb_bytesel  (vwb_bytesel),
    .vwb_ack      (vwb_ack),
    .d_addr       (d_addr),
    .d_data       (d_data),
    .d_bytesel    (d_bytesel),
    .d_access     (d_access),
    .d_wr_en      (d_wr_en),
    .d_ack        (d_ack),
    .probe_addr   (probe_addr),
    .probe_hit    (probe_hit),
    .empty        (empty),
    .count        (count)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int pulse_req  = 0;
  int pulse_done = 0;
  bit auto_drain = 1'b0;
  bit force_ack  = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- d_ack driver (runs after the main thread each cycle) ----
  initial begin
    d_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) d_ack = 1'b1;
      else if (d_ack) d_ack = 1'b0;
      else if (pulse_req != pulse_done) begin
        d_ack = 1'b1;
        pulse_done++;
      end
      else if (auto_drain && d_access) d_ack = 1'b1;
      else d_ack = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && d_access && d_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_drain", {d_addr, d_data, d_bytesel}, '0);
        end else begin
          e = exp_q.pop_front();
          check("drain_entry", {d_addr, d_data, d_bytesel}, e);
          check("d_wr_en", d_wr_en, 1);
        end
        pops++;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [15:0] d,
                          input logic [1:0] be, input bit push, input int exp_lat);
    int lat;
    bit got;
    if (push) exp_q.push_back({a, d, be});
    vwb_addr = a; vwb_data_out = d; vwb_bytesel = be;
    vwb_wr_en = 1'b1; vwb_access = 1'b1;
    lat = 0; got = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (vwb_ack) got = 1'b1;
    end
    vwb_access = 1'b0;
    if (!got) check("ack_timeout", 0, 1);
    else if (exp_lat > 0) check("ack_latency", lat, exp_lat);
    @(posedge clk); #1;
    check("ack_one_cycle", vwb_ack, 0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!empty && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", empty, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit seen;
    int p0;
    reset = 1'b1;
    vwb_addr = '0; vwb_data_out = '0; vwb_access = 1'b0; vwb_wr_en = 1'b0;
    vwb_bytesel = 2'b00; probe_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vwb_ack", vwb_ack, 0);
    check("rst_d_access", d_access, 0);
    check("rst_d_wr_en", d_wr_en, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_probe_hit", probe_hit, 0);
    check("rst_d_fields", {d_addr, d_data, d_bytesel}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single write, auto drain
    auto_drain = 1'b1;
    do_write(19'h00010, 16'hDEAD, 2'b11, 1, 1);
    wait_empty();
    check("single_count", count, 0);

    // fill to full, 5th stalls
    auto_drain = 1'b0;
    for (int i = 0; i < 4; i++) do_write(19'h00010 + 19'(i), 16'h1000 + 16'(i), 2'b11, 1, 1);
    check("full_count", count, 4);
    check("full_d_access", d_access, 1);
    probe_addr = 19'h00011; #1;
    check("probe_hit_queued", probe_hit, 1);
    probe_addr = 19'h08011; #1;
    check("probe_miss_alias", probe_hit, 0);
    exp_q.push_back({19'h00014, 16'h1004, 2'b11});
    vwb_addr = 19'h00014; vwb_data_out = 16'h1004; vwb_bytesel = 2'b11;
    vwb_wr_en = 1'b1; vwb_access = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (vwb_ack) seen = 1'b1;
    end
    check("full_no_ack", seen, 0);
    check("full_count_held", count, 4);
    pulse_req++;
    n = 0;
    while (count != 3 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("pop_count3", count, 3);
    check("no_ack_on_pop_cycle", vwb_ack, 0);
    @(posedge clk); #1;
    check("ack_after_room", vwb_ack, 1);
    check("refill_count", count, 4);
    vwb_access = 1'b0;
    @(posedge clk); #1;
    probe_addr = 19'h00011; #1;
    check("probe_hit_head", probe_hit, 1);
    probe_addr = 19'h00010; #1;
    check("probe_drained", probe_hit, 0);
    probe_addr = 19'h00011;
    auto_drain = 1'b1;
    wait_empty();
    check("probe_after_drain", probe_hit, 0);

    // zero byte-enable write
    do_write(19'h00030, 16'h1234, 2'b00, 0, 1);
    check("be0_count", count, 0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (d_access) seen = 1'b1;
    end
    check("be0_no_access", seen, 0);
    // d_ack while empty
    auto_drain = 1'b0;
    p0 = pops;
    pulse_req++;
    repeat (3) begin @(posedge clk); #1; end
    check("empty_ack_count", count, 0);
    check("empty_ack_empty", empty, 1);
    check("empty_ack_pops", pops - p0, 0);

    // reset mid-operation
    do_write(19'h00040, 16'h4000, 2'b11, 1, 1);
    do_write(19'h00041, 16'h4001, 2'b11, 1, 1);
    do_write(19'h00042, 16'h4002, 2'b11, 1, 1);
    check("pre_rst_count", count, 3);
    check("pre_rst_access", d_access, 1);
    reset = 1'b1; force_ack = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_access", d_access, 0);
    check("mid_rst_count", count, 0);
    @(posedge clk); #1;
    reset = 1'b0; force_ack = 1'b0;
    @(posedge clk); #1;
    check("post_rst_count", count, 0);
    check("post_rst_empty", empty, 1);
    p0 = pops;
    auto_drain = 1'b1;
    do_write(19'h00020, 16'hBEEF, 2'b11, 1, 1);
    wait_empty();
    check("post_rst_sole", pops - p0, 1);

    // coalesce scenario
    auto_drain = 1'b0;
    do_write(19'h00010, 16'h1111, 2'b11, 1, 1);
`ifdef VWB_COALESCE_EN
    do_write(19'h00018, 16'hAB00, 2'b10, 0, 1);
    exp_q.push_back({19'h00018, 16'hABCD, 2'b11});
    do_write(19'h00018, 16'h00CD, 2'b01, 0, 1);
    check("coalesce_count", count, 2);
`else
    do_write(19'h00018, 16'hAB00, 2'b10, 1, 1);
    do_write(19'h00018, 16'h00CD, 2'b01, 1, 1);
    check("no_coalesce_count", count, 3);
`endif
    probe_addr = 19'h00018; #1;
    check("probe_hit_18", probe_hit, 1);
    auto_drain = 1'b1;
    wait_empty();

    // burst with concurrent drain, crosses pointer wrap
    for (int i = 0; i < 6; i++) begin
      do_write(19'h00050 + 19'(i), 16'h5A00 + 16'(i * 17), (i % 3 == 0) ? 2'b01 : 2'b11, 1, 1);
    end
    wait_empty();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
